// File: rtl/sdram_refresh_timer.sv
// Refresh scheduler: divides HCLK into ticks, counts tREF intervals and tracks owed
// auto-refresh commands offered to the command sequencer through a req/ack handshake.
module sdram_refresh_timer #(
    parameter int PRESCALE     = 16,
    parameter int MAX_PENDING  = 8,
    parameter int URGENT_LEVEL = 4,
    localparam int PENDW       = $clog2(MAX_PENDING + 1)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             enable_i,
    input  logic [15:0]      tref_i,
    input  logic             rfr_ack_i,
    input  logic             ovf_clr_i,
    output logic             rfr_req_o,
    output logic             rfr_urgent_o,
    output logic [PENDW-1:0] rfr_pending_o,
    output logic             rfr_overflow_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_RELOAD = PW'(PRESCALE - 1);
    localparam logic [PENDW-1:0] PEND_MAX   = PENDW'(MAX_PENDING);
    localparam logic [PENDW-1:0] PEND_URG   = PENDW'(URGENT_LEVEL);

    logic [PW-1:0]    prescale_reg;
    logic [15:0]      interval_reg;
    logic [PENDW-1:0] pending_reg;
    logic             overflow_reg;

    logic             tick;
    logic             expiry;
    logic             ack_valid;
    logic [15:0]      interval_reload;

    always_comb begin
        tick            = enable_i && (prescale_reg == '0);
        // A zero tREF never expires; the counter just parks at zero.
        expiry          = tick && (interval_reg == 16'd0) && (tref_i != 16'd0);
        ack_valid       = rfr_ack_i && (pending_reg != '0);
        interval_reload = (tref_i == 16'd0) ? 16'd0 : (tref_i - 16'd1);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prescale_reg <= PRE_RELOAD;
            interval_reg <= 16'd0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (!enable_i) begin
                prescale_reg <= PRE_RELOAD;
                interval_reg <= interval_reload;
                pending_reg  <= '0;
            end else begin
                prescale_reg <= tick ? PRE_RELOAD : (prescale_reg - PW'(1));
                if (tick) begin
                    if (interval_reg == 16'd0)
                        interval_reg <= interval_reload;
                    else
                        interval_reg <= interval_reg - 16'd1;
                end
                if (expiry && !ack_valid) begin
                    if (pending_reg != PEND_MAX)
                        pending_reg <= pending_reg + PENDW'(1);
                end else if (!expiry && ack_valid) begin
                    pending_reg <= pending_reg - PENDW'(1);
                end
            end

            // Setting wins over a same-cycle clear so no overflow event is lost.
            if (enable_i && expiry && !ack_valid && (pending_reg == PEND_MAX))
                overflow_reg <= 1'b1;
            else if (ovf_clr_i)
                overflow_reg <= 1'b0;
        end
    end

    assign rfr_pending_o  = pending_reg;
    assign rfr_req_o      = (pending_reg != '0);
    assign rfr_urgent_o   = (pending_reg >= PEND_URG);
    assign rfr_overflow_o = overflow_reg;

endmodule

// File: tb/tb_sdram_refresh_timer.sv
// Directed bench for sdram_refresh_timer with PRESCALE=4, MAX_PENDING=8, URGENT_LEVEL=4.
module tb_sdram_refresh_timer;

    logic        HCLK;
    logic        HRESETn;
    logic        enable_i;
    logic [15:0] tref_i;
    logic        rfr_ack_i;
    logic        ovf_clr_i;
    logic        rfr_req_o;
    logic        rfr_urgent_o;
    logic [3:0]  rfr_pending_o;
    logic        rfr_overflow_o;

    int checks = 0;
    int errors = 0;
    int exp_pend;

    sdram_refresh_timer #(
        .PRESCALE     (4),
        .MAX_PENDING  (8),
        .URGENT_LEVEL (4)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .enable_i       (enable_i),
        .tref_i         (tref_i),
        .rfr_ack_i      (rfr_ack_i),
        .ovf_clr_i      (ovf_clr_i),
        .rfr_req_o      (rfr_req_o),
        .rfr_urgent_o   (rfr_urgent_o),
        .rfr_pending_o  (rfr_pending_o),
        .rfr_overflow_o (rfr_overflow_o)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn   = 1'b0;
        enable_i  = 1'b0;
        tref_i    = 16'd3;
        rfr_ack_i = 1'b0;
        ovf_clr_i = 1'b0;
        #25;
        check("rst_pending", 32'(rfr_pending_o), 0);
        check("rst_req", 32'(rfr_req_o), 0);
        check("rst_urgent", 32'(rfr_urgent_o), 0);
        check("rst_ovf", 32'(rfr_overflow_o), 0);
        #2 HRESETn = 1'b1;
        step(2);
        check("idle_pending", 32'(rfr_pending_o), 0);

        // 1: first request exactly 12 edges after enable, then every 12
        enable_i = 1'b1;
        step(11);
        check("t1_req_before", 32'(rfr_req_o), 0);
        step(1);
        check("t1_req_at12", 32'(rfr_req_o), 1);
        check("t1_pend_at12", 32'(rfr_pending_o), 1);
        step(11);
        check("t1_pend_at23", 32'(rfr_pending_o), 1);
        step(1);
        check("t1_pend_at24", 32'(rfr_pending_o), 2);

        // 2: saturate at 8, overflow on the 9th, then clear
        step(72);
        check("t2_pend_sat", 32'(rfr_pending_o), 8);
        check("t2_urgent", 32'(rfr_urgent_o), 1);
        check("t2_ovf_before", 32'(rfr_overflow_o), 0);
        step(12);
        check("t2_pend_9th", 32'(rfr_pending_o), 8);
        check("t2_ovf_set", 32'(rfr_overflow_o), 1);
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        check("t2_ovf_clr", 32'(rfr_overflow_o), 0);

        // 3: expiry and ack together at pending 8 (edge 120)
        step(10);
        rfr_ack_i = 1'b1;
        step(1);
        check("t3_pend_hold", 32'(rfr_pending_o), 8);
        check("t3_no_ovf", 32'(rfr_overflow_o), 0);

        // 4: drop to 5, then back-to-back acks past zero (edges 121..129)
        exp_pend = 8;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (exp_pend > 0) exp_pend--;
            if (i >= 3) begin
                check($sformatf("t4_pend_ack%0d", i), 32'(rfr_pending_o), 32'(exp_pend));
                check($sformatf("t4_urg_ack%0d", i), 32'(rfr_urgent_o), (exp_pend >= 4) ? 1 : 0);
                check($sformatf("t4_req_ack%0d", i), 32'(rfr_req_o), (exp_pend != 0) ? 1 : 0);
            end
        end
        rfr_ack_i = 1'b0;

        // 5: tREF 3->10 mid-interval: expiry at edge 132 then edge 172
        tref_i = 16'd10;
        step(3);
        check("t5_old_interval", 32'(rfr_pending_o), 1);
        rfr_ack_i = 1'b1;
        step(1);
        rfr_ack_i = 1'b0;
        check("t5_acked", 32'(rfr_pending_o), 0);
        step(38);
        check("t5_new_before", 32'(rfr_pending_o), 0);
        step(1);
        check("t5_new_at40", 32'(rfr_pending_o), 1);
        tref_i = 16'd0;
        rfr_ack_i = 1'b1;
        step(1);
        rfr_ack_i = 1'b0;
        step(100);
        check("t5_tref0_none", 32'(rfr_pending_o), 0);
        check("t5_tref0_req", 32'(rfr_req_o), 0);

        // 6: enable low clears pending; async reset clears immediately
        tref_i   = 16'd3;
        enable_i = 1'b0;
        step(1);
        enable_i = 1'b1;
        step(36);
        check("t6_pend3", 32'(rfr_pending_o), 3);
        check("t6_urg3", 32'(rfr_urgent_o), 0);
        enable_i = 1'b0;
        step(1);
        check("t6_dis_pend", 32'(rfr_pending_o), 0);
        check("t6_dis_req", 32'(rfr_req_o), 0);
        enable_i = 1'b1;
        step(24);
        check("t6_pend2", 32'(rfr_pending_o), 2);
        HRESETn = 1'b0;
        #1;
        check("t6_rst_pend", 32'(rfr_pending_o), 0);
        check("t6_rst_req", 32'(rfr_req_o), 0);
        enable_i = 1'b0;
        step(2);
        HRESETn = 1'b1;
        step(2);
        check("t6_after_rst", 32'(rfr_pending_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
